// File: rtl/ram_initiator.sv
// ram_initiator: burst read/write front-end for a single-port RAM with a one-cycle registered read.
// Define RAM_INIT_WRITE_VERIFY_EN to build the per-beat write read-back check that drives verify_err.
module ram_initiator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [3:0]       cmd_len,
  input  logic             wdata_valid,
  input  logic [WIDTH-1:0] wdata,
  output logic             wdata_ready,
  output logic             rdata_valid,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_last,
  input  logic             rdata_ready,
  output logic             busy,
  output logic             verify_err,
  output logic             ram_wr_en,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WR       = 3'd1;
  localparam logic [2:0] ST_RD_REQ   = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_RSP   = 3'd4;
`ifdef RAM_INIT_WRITE_VERIFY_EN
  localparam logic [2:0] ST_VFY_REQ  = 3'd5;
  localparam logic [2:0] ST_VFY_WAIT = 3'd6;
`endif

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [2:0]       state_reg, state_next;
  logic [AW-1:0]    cur_addr_reg, cur_addr_next;
  logic [3:0]       beats_left_reg, beats_left_next;
  logic [WIDTH-1:0] rdata_reg, rdata_next;
  logic [AW-1:0]    addr_inc;
  logic             last_beat;

  // Explicit wrap so non-power-of-two depths never address past the last word.
  assign addr_inc  = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + 1'b1;
  assign last_beat = (beats_left_reg == 4'd0);

`ifdef RAM_INIT_WRITE_VERIFY_EN
  logic [WIDTH-1:0] wsave_reg, wsave_next;
  logic             verify_err_reg, verify_err_next;
`endif

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    beats_left_next = beats_left_reg;
    rdata_next      = rdata_reg;
`ifdef RAM_INIT_WRITE_VERIFY_EN
    wsave_next      = wsave_reg;
    verify_err_next = verify_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_next   = cmd_addr;
          beats_left_next = cmd_len;
`ifdef RAM_INIT_WRITE_VERIFY_EN
          verify_err_next = 1'b0;
`endif
          state_next      = cmd_write ? ST_WR : ST_RD_REQ;
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
`ifdef RAM_INIT_WRITE_VERIFY_EN
          wsave_next = wdata;
          state_next = ST_VFY_REQ;
`else
          cur_addr_next = addr_inc;
          if (last_beat) begin
            state_next = ST_IDLE;
          end else begin
            beats_left_next = beats_left_reg - 4'd1;
          end
`endif
        end
      end
      ST_RD_REQ: begin
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rdata_next = ram_rdata;
        state_next = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        if (rdata_ready) begin
          if (last_beat) begin
            state_next = ST_IDLE;
          end else begin
            cur_addr_next   = addr_inc;
            beats_left_next = beats_left_reg - 4'd1;
            state_next      = ST_RD_REQ;
          end
        end
      end
`ifdef RAM_INIT_WRITE_VERIFY_EN
      ST_VFY_REQ: begin
        state_next = ST_VFY_WAIT;
      end
      ST_VFY_WAIT: begin
        if (ram_rdata != wsave_reg) begin
          verify_err_next = 1'b1;
        end
        cur_addr_next = addr_inc;
        if (last_beat) begin
          state_next = ST_IDLE;
        end else begin
          beats_left_next = beats_left_reg - 4'd1;
          state_next      = ST_WR;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cur_addr_reg   <= '0;
      beats_left_reg <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      beats_left_reg <= beats_left_next;
      rdata_reg      <= rdata_next;
    end
  end

`ifdef RAM_INIT_WRITE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wsave_reg      <= '0;
      verify_err_reg <= 1'b0;
    end else begin
      wsave_reg      <= wsave_next;
      verify_err_reg <= verify_err_next;
    end
  end

  assign verify_err = verify_err_reg;
  assign ram_rd_en  = (state_reg == ST_RD_REQ) || (state_reg == ST_VFY_REQ);
`else
  assign verify_err = 1'b0;
  assign ram_rd_en  = (state_reg == ST_RD_REQ);
`endif

  // Write strobe follows the client's valid directly so a gap costs no extra cycles.
  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign wdata_ready = (state_reg == ST_WR);
  assign ram_wr_en   = (state_reg == ST_WR) && wdata_valid;
  assign ram_wdata   = (state_reg == ST_WR) ? wdata : '0;
  assign ram_addr    = cur_addr_reg;
  assign rdata_valid = (state_reg == ST_RD_RSP);
  assign rdata_last  = (state_reg == ST_RD_RSP) && last_beat;
  assign rdata       = rdata_reg;

endmodule

// File: tb/tb_ram_initiator.sv
// tb_ram_initiator: randomized and directed bursts checked against a shadow-memory model of
// the RAM contents and expected-beat queues; includes a registered-read RAM model.
`timescale 1ns/1ps
module tb_ram_initiator;
  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [3:0]       cmd_len;
  logic             wdata_valid, wdata_ready;
  logic [WIDTH-1:0] wdata;
  logic             rdata_valid, rdata_last, rdata_ready;
  logic [WIDTH-1:0] rdata;
  logic             busy, verify_err;
  logic             ram_wr_en, ram_rd_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .rdata_ready(rdata_ready), .busy(busy), .verify_err(verify_err),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM with one-cycle registered read; can corrupt reads of word 7.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic             corrupt_en = 1'b0;
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= (corrupt_en && ram_addr == AW'(7)) ? ~ram_mem[ram_addr] : ram_mem[ram_addr];
  end

`ifdef RAM_INIT_WRITE_VERIFY_EN
  localparam int WR_STEP  = 3;
  localparam int GAP_SPAN = 9;
`else
  localparam int WR_STEP  = 1;
  localparam int GAP_SPAN = 5;
`endif

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [AW-1:0] addr; logic [WIDTH-1:0] data; } wr_t;
  typedef struct packed { logic [WIDTH-1:0] data; logic last; } rd_t;

  wr_t              wq[$];
  rd_t              rq[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [AW-1:0]    wr_log[$];
  logic [WIDTH-1:0] rd_log[$];

  int cyc = 0;
  int accept_cyc = 0;
  int rd_en_cnt = 0, wr_en_cnt = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1;
  int first_rv_cyc = -1;
  int first_hs_cyc = -1, last_hs_cyc = -1;
  bit mon_on = 0;
  int rr_mode = 0;
  logic rr_man = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       rdata_ready = 1'b1;
        1:       rdata_ready = 1'($urandom_range(0, 1));
        default: rdata_ready = rr_man;
      endcase
    end
  end

  // Compare process: every cycle outside reset, checked against the expected queues.
  initial begin
    wr_t w;
    rd_t r;
    logic             stall_prev;
    logic [WIDTH-1:0] rdata_prev;
    stall_prev = 1'b0;
    rdata_prev = '0;
    forever begin
      @(negedge clk);
      if (rst || !mon_on) begin
        stall_prev = 1'b0;
        continue;
      end
      chk("strobe_excl", 32'(ram_wr_en & ram_rd_en), 32'd0);
      if (ram_rd_en) rd_en_cnt++;
      if (ram_wr_en) begin
        wr_en_cnt++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_log.push_back(ram_addr);
        if (wq.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(w.addr));
          chk("wr_data", 32'(ram_wdata), 32'(w.data));
          model_mem[w.addr] = w.data;
        end
      end
      if (stall_prev) begin
        chk("rvalid_held", 32'(rdata_valid), 32'd1);
        chk("rdata_held", 32'(rdata), 32'(rdata_prev));
      end
      if (rdata_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (rdata_valid && rdata_ready) begin
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        rd_log.push_back(rdata);
        if (rq.size() == 0) chk("unexpected_rd", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("rdata", 32'(rdata), 32'(r.data));
          chk("rdata_last", 32'(rdata_last), 32'(r.last));
        end
      end
      stall_prev = rdata_valid && !rdata_ready;
      rdata_prev = rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin step(); n++; end
    if (busy) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = 4'(len);
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (!cmd_ready) chk("cmd_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_len   = 4'($urandom);
  endtask

  task automatic do_write(input int addr, input int len, input logic [WIDTH-1:0] data [16],
                          input int gap_beat, input int gap_len, input bit rnd_gaps);
    wr_t w;
    int  n;
    int  g;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      g = 0;
      if (i == gap_beat) g = gap_len;
      else if (rnd_gaps && ($urandom_range(0, 3) == 0)) g = $urandom_range(1, 2);
      wdata_valid = 1'b0;
      repeat (g) begin wdata = WIDTH'($urandom); step(); end
      wdata_valid = 1'b1;
      wdata = data[i];
      w.addr = AW'((addr + i) % DEPTH);
      w.data = data[i];
      wq.push_back(w);
      n = 0;
      while (!wdata_ready && n < 50) begin step(); n++; end
      if (!wdata_ready) chk("wready_timeout", 32'd0, 32'd1);
      step();
    end
    wdata_valid = 1'b0;
    wait_idle();
    chk("wr_beats_left", 32'(wq.size()), 32'd0);
    wq.delete();
  endtask

  task automatic push_reads(input int addr, input int len);
    rd_t r;
    for (int i = 0; i <= len; i++) begin
      r.data = model_mem[(addr + i) % DEPTH];
      r.last = (i == len);
      rq.push_back(r);
    end
  endtask

  task automatic do_read(input int addr, input int len);
    push_reads(addr, len);
    send_cmd(1'b0, addr, len);
    wait_idle();
    chk("rd_beats_left", 32'(rq.size()), 32'd0);
    rq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] d [16];
    int n, c0, w0, a, l;

    // Reset with random inputs
    rst = 1'b1;
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_len = 4'($urandom); wdata_valid = 1'($urandom); wdata = WIDTH'($urandom);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("rst_rdata_last", 32'(rdata_last), 32'd0);
      chk("rst_verify_err", 32'(verify_err), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    wdata_valid = 1'b0;
    step();
    mon_on = 1;

    // Fill the whole RAM so every later read has a known expected value
    for (int k = 0; k < 16; k++) d[k] = WIDTH'($urandom);
    do_write(0, 15, d, -1, 0, 1'b0);
    for (int k = 0; k < 16; k++) d[k] = WIDTH'($urandom);
    do_write(16, 15, d, -1, 0, 1'b0);

    // Write A0..A3 at 5, back-to-back
    for (int k = 0; k < 16; k++) d[k] = WIDTH'(8'hA0 + k);
    wr_log.delete(); first_wr_cyc = -1; w0 = wr_en_cnt;
    do_write(5, 3, d, -1, 0, 1'b0);
    chk("wr_count", 32'(wr_en_cnt - w0), 32'd4);
    chk("wr_span", 32'(last_wr_cyc - first_wr_cyc), 32'(3 * WR_STEP));
    for (int k = 0; k < 4; k++) chk("wr_addr_seq", 32'(wr_log[k]), 32'(5 + k));
    chk("verify_err_clean", 32'(verify_err), 32'd0);

    // Read it back: latency, throughput, literal data
    rd_log.delete(); first_rv_cyc = -1; first_hs_cyc = -1; c0 = rd_en_cnt;
    do_read(5, 3);
    chk("rd_latency", 32'(first_rv_cyc - accept_cyc), 32'd2);
    chk("rd_throughput", 32'(last_hs_cyc - first_hs_cyc), 32'd9);
    chk("rd_en_count", 32'(rd_en_cnt - c0), 32'd4);
    for (int k = 0; k < 4; k++) chk("rd_lit", 32'(rd_log[k]), 32'(8'hA0 + k));

    // Address wrap
    for (int k = 0; k < 16; k++) d[k] = WIDTH'(8'hB0 + k);
    wr_log.delete();
    do_write(30, 3, d, -1, 0, 1'b0);
    chk("wrap_a0", 32'(wr_log[0]), 32'd30);
    chk("wrap_a1", 32'(wr_log[1]), 32'd31);
    chk("wrap_a2", 32'(wr_log[2]), 32'd0);
    chk("wrap_a3", 32'(wr_log[3]), 32'd1);
    rd_log.delete();
    do_read(30, 3);
    for (int k = 0; k < 4; k++) chk("wrap_rd", 32'(rd_log[k]), 32'(8'hB0 + k));

    // Write back-pressure: 2 idle cycles before beat 2
    for (int k = 0; k < 16; k++) d[k] = WIDTH'($urandom);
    first_wr_cyc = -1;
    do_write(10, 3, d, 2, 2, 1'b0);
    chk("gap_span", 32'(last_wr_cyc - first_wr_cyc), 32'(GAP_SPAN));

    // Read back-pressure: ready low 5 cycles
    rr_mode = 2; rr_man = 1'b0;
    push_reads(10, 3);
    send_cmd(1'b0, 10, 3);
    n = 0;
    while (!rdata_valid && n < 20) begin step(); n++; end
    chk("stall_rvalid_seen", 32'(rdata_valid), 32'd1);
    c0 = rd_en_cnt;
    repeat (5) step();
    chk("stall_rvalid", 32'(rdata_valid), 32'd1);
    chk("stall_no_rd_en", 32'(rd_en_cnt - c0), 32'd0);
    rr_man = 1'b1;
    wait_idle();
    chk("stall_rd_left", 32'(rq.size()), 32'd0);
    rq.delete();
    rr_mode = 0;
    step();

    // Reset during beat 2 of a 4-beat read
    push_reads(20, 3);
    rd_log.delete();
    send_cmd(1'b0, 20, 3);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_beats_done", 32'(rd_log.size()), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rvalid", 32'(rdata_valid), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    rq.delete();
    c0 = rd_en_cnt;
    repeat (5) step();
    chk("midrst_no_rd_en", 32'(rd_en_cnt - c0), 32'd0);
    do_read(20, 3);

    // Write verify against a RAM that corrupts word 7
    for (int k = 0; k < 16; k++) d[k] = WIDTH'(8'hC0 + k);
    corrupt_en = 1'b1;
    do_write(5, 3, d, -1, 0, 1'b0);
    corrupt_en = 1'b0;
`ifdef RAM_INIT_WRITE_VERIFY_EN
    chk("verify_err_set", 32'(verify_err), 32'd1);
    repeat (3) step();
    chk("verify_err_sticky", 32'(verify_err), 32'd1);
    do_read(0, 0);
    chk("verify_err_clear", 32'(verify_err), 32'd0);
`else
    chk("verify_err_off", 32'(verify_err), 32'd0);
`endif

    // Randomized bursts
    rr_mode = 1;
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 16; k++) d[k] = WIDTH'($urandom);
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 15);
      do_write(a, l, d, -1, 0, 1'b1);
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, 15);
      do_read(a, l);
    end
    rr_mode = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_initiator.md
# ram_initiator

Bus-side initiator for the single-port `ram` block: it accepts burst read/write commands over valid/ready handshakes and sequences them onto the RAM's `wr_en`/`rd_en`/`address`/`data_in` pins, collecting `data_out` for reads. It sits between a client (test sequencer, DMA, CPU bridge) and one `ram` instance, and owns the RAM's one-cycle registered read latency. It also enforces the rule that `rd_en` and `wr_en` are never asserted together.

## Interface
- `WIDTH`, 8, data width; must match the RAM.
- `DEPTH`, 32, RAM word count; address width is `$clog2(DEPTH)` (written AW below).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  AW  start address.
- `cmd_len`  in  4  beats minus 1 (1..16 beats).
- `wdata_valid`  in  1  write beat offered.
- `wdata`  in  WIDTH  write beat data.
- `wdata_ready`  out  1  write beat accepted.
- `rdata_valid`  out  1  read beat available.
- `rdata`  out  WIDTH  read beat data.
- `rdata_last`  out  1  final beat of the burst.
- `rdata_ready`  in  1  client accepts read beat.
- `busy`  out  1  high whenever state is not IDLE.
- `verify_err`  out  1  sticky write-verify mismatch flag.
- `ram_wr_en`, `ram_rd_en`  out  1  drive the RAM `wr_en` and `rd_en` pins.
- `ram_addr`  out  AW  drives the RAM `address` pin.
- `ram_wdata`  out  WIDTH  drives the RAM `data_in` pin.
- `ram_rdata`  in  WIDTH  driven by the RAM `data_out` pin.

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, RD_RSP; VFY_REQ and VFY_WAIT exist only with the macro.
- Registers: `cur_addr` (AW bits), `beats_left` (4 bits), `rdata` (WIDTH bits), saved write data (WIDTH bits).
- IDLE: `cmd_ready`=1. On handshake, latch `cmd_addr` into `cur_addr` and `cmd_len` into `beats_left`, clear `verify_err`, then go to WR (write) or RD_REQ (read).
- WR:
  - `wdata_ready`=1.
  - `ram_wr_en` = `wdata_valid` (combinational), `ram_wdata`=`wdata`, `ram_addr`=`cur_addr`.
  - On each beat, increment `cur_addr`. When `beats_left`==0, go to IDLE; otherwise decrement `beats_left`.
- RD_REQ: `ram_rd_en`=1 and `ram_addr`=`cur_addr` for exactly one cycle, then RD_WAIT.
- RD_WAIT: capture `ram_rdata` into `rdata`, then RD_RSP.
- RD_RSP:
  - `rdata_valid`=1; `rdata_last`=(`beats_left`==0).
  - `rdata` is held stable until `rdata_ready`.
  - On handshake: if last beat, go to IDLE; otherwise increment `cur_addr`, decrement `beats_left`, go to RD_REQ.
- Address wrap: `cur_addr` increments from DEPTH-1 to 0, including when DEPTH is not a power of two.
- `ram_wr_en` and `ram_rd_en` are never high in the same cycle. Both are low in IDLE.
- A command arriving while `busy` is not accepted; it waits on `cmd_ready`.

## Timing
- Reset: the edge with `rst`=1 puts the block in IDLE. Reset values:
  - `cmd_ready`=1.
  - `busy`, `wdata_ready`, `rdata_valid`, `rdata_last`, `verify_err`, `ram_wr_en`, `ram_rd_en` all 0.
  - `ram_addr`, `ram_wdata`, `rdata` all 0.
- Reset mid-burst: the burst is abandoned, any pending `rdata` is dropped, and no further RAM strobes are issued.
- Write throughput: 1 beat/cycle. The RAM commits at the edge that ends the beat cycle.
- Read latency: accept at edge E0. RD_REQ is cycle 1, RD_WAIT cycle 2, `rdata_valid` high in cycle 3.
- Read throughput: 3 cycles/beat when `rdata_ready` is held high.
- Write-then-read: the read's `ram_rd_en` is at least 2 cycles after the last `ram_wr_en`, so it always sees the written data.

## Configuration
- `RAM_INIT_WRITE_VERIFY_EN` defined:
  - After each WR beat, save the data and go to VFY_REQ (`ram_rd_en`=1, same `cur_addr`), then VFY_WAIT.
  - VFY_WAIT compares `ram_rdata` to the saved data; a mismatch sets `verify_err`.
  - Then increment the address and return to WR, or go to IDLE after the last beat.
  - Write throughput becomes 3 cycles/beat; `wdata_ready` is high only in WR.
- Undefined: the verify states are not built, `verify_err` is tied to 0, and writes run at 1 beat/cycle.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs -> `cmd_ready`=1 and every other output 0 after the first reset edge; no RAM strobes.
- Write addr 5, `cmd_len`=3, data A0..A3 back-to-back -> `ram_wr_en` high 4 consecutive cycles at addresses 5..8. Then read the same range -> `rdata` A0..A3, first `rdata_valid` in cycle 3 after accept, `rdata_last` only on A3.
- Wrap: write addr 30, `cmd_len`=3 with DEPTH=32 -> `ram_addr` 30, 31, 0, 1; read-back returns the same data.
- Back-pressure: `wdata_valid` low 2 cycles mid-burst -> `ram_wr_en` low for those cycles. `rdata_ready` low 5 cycles -> `rdata`/`rdata_valid` held, no `ram_rd_en`.
- Reset during beat 2 of a 4-beat read -> IDLE next cycle, `rdata_valid`=0, no further `ram_rd_en`; the next command executes normally.
- With `RAM_INIT_WRITE_VERIFY_EN`, the RAM model corrupts address 7 -> `verify_err`=1 after that beat and stays set until the next command is accepted. Without the macro, `verify_err` stays 0 and throughput is 1 beat/cycle.
